adc_sample_unpacker: RTL

- Inverse of the capture-side packer: reads 32-bit tuple words {or, trig, s2[9:0], s1[9:0], s0[9:0]} from a first-word-fall-through FIFO filled from DDR, and emits one 10-bit sample per adc_sampleclk cycle, in order s0, s1, s2.
- Sits between the DDR read-back path and sample-domain consumers: trigger replay, pattern playback, self-test compare.
- Runs a playback of a programmed tuple count under a level go/done handshake.

---
 rtl/adc_sample_unpacker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adc_sample_unpacker.sv
// ---------------------------------------------------------------------------
// adc_sample_unpacker
//
// Replays packed ADC tuples from a first-word-fall-through FIFO as a stream of
// single samples. Each 32-bit FIFO word is {or, trig, s2, s1, s0}. One word
// becomes three consecutive samples (s0, s1, s2), one per adc_sampleclk cycle.
// A playback covers a programmed number of words. It is started and ended by
// a level go/done handshake.
//
// Ports:
//   adc_sampleclk  in   block clock
//   ddr_usrreset   in   asynchronous, active-high reset
//   play_go        in   level start; drop to acknowledge done or to abort
//   play_tuples    in   words to replay, latched when playback starts
//   fifo_dout      in   FWFT FIFO head word, valid while fifo_empty = 0
//   fifo_empty     in   FIFO empty flag
//   fifo_rd_en     out  FIFO pop (combinational)
//   sample_out     out  current sample
//   sample_valid   out  sample_out valid this cycle
//   sample_or      out  overrange flag of the word the sample came from
//   sample_trig    out  trigger flag of the word the sample came from
//   play_busy      out  playback running
//   play_done      out  playback complete, waiting for play_go = 0
//   underrun       out  sticky: FIFO was empty when a word was needed
//   tuple_count    out  words fully emitted in the current or last playback
// ---------------------------------------------------------------------------
module adc_sample_unpacker #(
   parameter int SAMPLE_W = 10,
   parameter int CNT_W    = 32
) (
   input  logic                    adc_sampleclk,
   input  logic                    ddr_usrreset,
   input  logic                    play_go,
   input  logic [CNT_W-1:0]        play_tuples,
   input  logic [3*SAMPLE_W+1:0]   fifo_dout,
   input  logic                    fifo_empty,
   output logic                    fifo_rd_en,
   output logic [SAMPLE_W-1:0]     sample_out,
   output logic                    sample_valid,
   output logic                    sample_or,
   output logic                    sample_trig,
   output logic                    play_busy,
   output logic                    play_done,
   output logic                    underrun,
   output logic [CNT_W-1:0]        tuple_count
);

   localparam int WORD_W = 3*SAMPLE_W + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [2:0]               phase;
   // Only s1 and s2 are kept; s0 goes straight from the FIFO head to the output.
   logic [2*SAMPLE_W-1:0]    word_hi;
   logic [CNT_W-1:0]         len;
   logic [CNT_W-1:0]         count_inc;
   logic                     last_word;

   assign count_inc = tuple_count + CNT_W'(1);
   assign last_word = (count_inc == len);

   assign play_busy = (state == RUN);
   assign play_done = (state == DONE);

   always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
      if (ddr_usrreset) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (play_go) state_nxt = (play_tuples != '0) ? RUN : DONE;
         end
         RUN: begin
            if (!play_go) begin
               // Abort: no pop in the cycle play_go is seen low.
               state_nxt = IDLE;
            end else begin
               if (phase[0] && !fifo_empty) fifo_rd_en = 1'b1;
               if (phase[2] && last_word)   state_nxt  = DONE;
            end
         end
         DONE: begin
            if (!play_go) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // --- sample stage: word capture and sample selection ---
   always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
      if (ddr_usrreset) begin
         phase        <= 3'b001;
         word_hi      <= '0;
         len          <= '0;
         tuple_count  <= '0;
         underrun     <= 1'b0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         sample_or    <= 1'b0;
         sample_trig  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sample_valid <= 1'b0;
               if (play_go) begin
                  len         <= play_tuples;
                  tuple_count <= '0;
                  underrun    <= 1'b0;
                  phase       <= 3'b001;
               end
            end
            RUN: begin
               if (!play_go) begin
                  // Partial word is dropped; tuple_count keeps what was completed.
                  sample_valid <= 1'b0;
               end else if (phase[0]) begin
                  if (!fifo_empty) begin
                     word_hi      <= fifo_dout[3*SAMPLE_W-1:SAMPLE_W];
                     sample_out   <= fifo_dout[SAMPLE_W-1:0];
                     sample_or    <= fifo_dout[WORD_W-1];
                     sample_trig  <= fifo_dout[WORD_W-2];
                     sample_valid <= 1'b1;
                     phase        <= 3'b010;
                  end else begin
                     sample_valid <= 1'b0;
                     underrun     <= 1'b1;
                  end
               end else if (phase[1]) begin
                  sample_out   <= word_hi[SAMPLE_W-1:0];
                  sample_valid <= 1'b1;
                  phase        <= 3'b100;
               end else begin
                  sample_out   <= word_hi[2*SAMPLE_W-1:SAMPLE_W];
                  sample_valid <= 1'b1;
                  tuple_count  <= count_inc;
                  phase        <= 3'b001;
               end
            end
            default: begin
               sample_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
